wide_alu_sched: RTL and testbench
=================================

// Module: wide_alu_sched
//
// PURPOSE
// - Round-robin scheduler sharing one wide ALU instance between NUM_REQ requesters.
// - Accepts one operation at a time (op_a, op_b, opsel) and pulses the ALU trigger.
// - Waits for ALU completion, then returns result/error to the granted requester via valid/ready.
// - Sits between requester masters (DMA, core shims) and the wide ALU datapath, in place of direct regfile drive.
//
// PARAMETERS
// - NUM_REQ     default 4     number of requesters, 2..8
// - OP_WIDTH    default 1024  operand width in bits
// - RES_WIDTH   default 2048  result width in bits (2*OP_WIDTH)
// - TIMEOUT_CYC default 4096  watchdog limit in cycles (used only with WIDE_ALU_SCHED_TIMEOUT_EN)
//
// PORTS
// - clk_i            in   1                   clock
// - rst_i            in   1                   reset, asynchronous, active-high
// - req_valid_i      in   NUM_REQ             per-requester operation request
// - req_ready_o      out  NUM_REQ             one-hot grant; request accepted when valid&ready
// - req_op_a_i       in   NUM_REQ*OP_WIDTH    packed operand A, requester i at [i*OP_WIDTH +: OP_WIDTH]
// - req_op_b_i       in   NUM_REQ*OP_WIDTH    packed operand B
// - req_opsel_i      in   NUM_REQ*3           packed opsel: 0 ADD, 1 SUB, 2 MUL, 3 XOR, 4 AND, 5 OR
// - rsp_valid_o      out  NUM_REQ             one-hot response valid, to the granted requester only
// - rsp_ready_i      in   NUM_REQ             per-requester response ready
// - rsp_result_o     out  RES_WIDTH           result (shared bus, qualified by rsp_valid_o)
// - rsp_err_o        out  1                   response carries an error (bad opsel, ALU error, timeout)
// - alu_op_a_o       out  OP_WIDTH            operand A to ALU, held stable ISSUE..WAIT
// - alu_op_b_o       out  OP_WIDTH            operand B to ALU
// - alu_opsel_o      out  3                   opsel to ALU
// - alu_trigger_o    out  1                   single-cycle start pulse
// - alu_clear_err_o  out  1                   single-cycle ALU error-clear pulse
// - alu_done_i       in   1                   single-cycle completion pulse, result valid in same cycle
// - alu_err_i        in   1                   single-cycle ALU error pulse
// - alu_result_i     in   RES_WIDTH           ALU result
// - busy_o           out  1                   FSM not in IDLE
//
// BEHAVIOUR
// - Reset: FSM=IDLE, rr pointer=0, all outputs 0, operand/result registers 0.
// - FSM states: IDLE, ISSUE, WAIT, RESP.
// - IDLE: if any req_valid_i, grant the first valid index at or after rr pointer (wrapping modulo NUM_REQ).
//   - req_ready_o[g]=1 combinationally in that cycle only.
//   - Capture op_a, op_b, opsel and g into registers.
//   - opsel<=5 -> ISSUE.
//   - opsel 6/7 -> RESP with err=1, result=0, no trigger.
// - ISSUE: alu_trigger_o=1 for exactly this cycle -> WAIT.
// - WAIT:
//   - alu_done_i=1 -> register alu_result_i, err=0 -> RESP.
//   - alu_err_i=1 -> err=1, result=0, alu_clear_err_o=1 next cycle (in RESP) -> RESP.
//   - done and err in the same cycle: err takes priority.
// - RESP: rsp_valid_o[g]=1; result/err held stable until rsp_ready_i[g]=1.
//   - Then -> IDLE, rr pointer=(g+1) mod NUM_REQ.
//   - rsp_ready_i of non-granted requesters is ignored.
// - Minimum latency: accept at cycle 0, trigger cycle 1, done earliest cycle 2, rsp_valid_o cycle 3.
// - One outstanding op only; req_ready_o=0 in all states except IDLE. No new grant in the cycle RESP completes.
// - Fairness: a continuously requesting requester waits at most NUM_REQ-1 operations.
// - alu_done_i/alu_err_i outside WAIT are ignored.
// - Reset mid-op: FSM returns to IDLE immediately; in-flight response is dropped; no trigger/clear pulse emitted.
//
// CONFIGURATION
// - WIDE_ALU_SCHED_TIMEOUT_EN defined:
//   - A 16-bit counter runs in WAIT, cleared on entry.
//   - Reaching TIMEOUT_CYC without done/err -> err=1, result=0, alu_clear_err_o pulse -> RESP.
// - WIDE_ALU_SCHED_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely until done/err.
//
// TESTING
// - Single req0: ADD a=5 b=7, ALU done 4 cycles after trigger -> one trigger pulse, rsp_valid_o=0001, result=12, err=0.
// - Requesters 0-3 all valid continuously, rr=0 -> grant order 0,1,2,3,0; each rsp to its own index only.
// - req2 opsel=7 -> req_ready_o=0100, no alu_trigger_o, rsp_valid_o=0100 next cycle, err=1, result=0.
// - ALU err pulse in WAIT (same cycle as done) -> err=1, one alu_clear_err_o pulse, rsp valid held while rsp_ready_i=0 for 5 cycles.
// - With TIMEOUT_EN, TIMEOUT_CYC=16, no done -> err response 16 cycles after entering WAIT; without TIMEOUT_EN, busy_o stays 1.
// - rst_i asserted in WAIT -> busy_o=0, rsp_valid_o=0 asynchronously; a later done pulse is ignored; next request served normally.

Source files
------------

// File: rtl/wide_alu_sched.sv
`default_nettype none
// ============================================================================
// Module : wide_alu_sched
// Desc   : Round-robin scheduler sharing one wide ALU between NUM_REQ requesters.
//          Optional WAIT watchdog enabled by defining WIDE_ALU_SCHED_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module wide_alu_sched #(
  parameter int NUM_REQ     = 4,
  parameter int OP_WIDTH    = 1024,
  parameter int RES_WIDTH   = 2048,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*OP_WIDTH-1:0] req_op_a_i,
  input  logic [NUM_REQ*OP_WIDTH-1:0] req_op_b_i,
  input  logic [NUM_REQ*3-1:0]        req_opsel_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output logic [RES_WIDTH-1:0]        rsp_result_o,
  output logic                        rsp_err_o,
  output logic [OP_WIDTH-1:0]         alu_op_a_o,
  output logic [OP_WIDTH-1:0]         alu_op_b_o,
  output logic [2:0]                  alu_opsel_o,
  output logic                        alu_trigger_o,
  output logic                        alu_clear_err_o,
  input  logic                        alu_done_i,
  input  logic                        alu_err_i,
  input  logic [RES_WIDTH-1:0]        alu_result_i,
  output logic                        busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_gnt;
  logic [IDX_W-1:0]     w_gnt_idx;
  logic                 w_gnt_vld;
  logic [2:0]           w_req_opsel;
  logic [OP_WIDTH-1:0]  r_op_a;
  logic [OP_WIDTH-1:0]  r_op_b;
  logic [2:0]           r_opsel;
  logic [RES_WIDTH-1:0] r_result;
  logic                 r_err;
  logic                 r_clear_err;
  logic                 w_timeout;
  logic                 w_fail;
  logic                 w_rsp_done;

  function automatic logic [IDX_W-1:0] f_wrap(input int v);
    return (v >= NUM_REQ) ? IDX_W'(v - NUM_REQ) : IDX_W'(v);
  endfunction

  // Scan from the highest offset down so the lowest offset from rr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[f_wrap(int'(r_rr_ptr) + k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = f_wrap(int'(r_rr_ptr) + k);
      end
    end
  end

  assign w_req_opsel = req_opsel_i[int'(w_gnt_idx)*3 +: 3];
  assign w_rsp_done  = (r_state == S_RESP) && rsp_ready_i[r_gnt];

`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
  logic [15:0] r_wd_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
    end else if (r_state != S_WAIT) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_fail = alu_err_i || w_timeout;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt = (w_req_opsel > 3'd5) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_fail || alu_done_i) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_opsel     <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
      r_clear_err <= 1'b0;
    end else begin
      // Error-clear follows the failing WAIT cycle, landing in the first RESP cycle.
      r_clear_err <= (r_state == S_WAIT) && w_fail;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_gnt    <= w_gnt_idx;
            r_op_a   <= req_op_a_i[int'(w_gnt_idx)*OP_WIDTH +: OP_WIDTH];
            r_op_b   <= req_op_b_i[int'(w_gnt_idx)*OP_WIDTH +: OP_WIDTH];
            r_opsel  <= w_req_opsel;
            r_err    <= (w_req_opsel > 3'd5);
            r_result <= '0;
          end
        end
        S_WAIT: begin
          if (w_fail) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else if (alu_done_i) begin
            r_err    <= 1'b0;
            r_result <= alu_result_i;
          end
        end
        S_RESP: begin
          if (w_rsp_done) begin
            r_rr_ptr <= (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if ((r_state == S_IDLE) && w_gnt_vld) begin
      req_ready_o[w_gnt_idx] = 1'b1;
    end
    if (r_state == S_RESP) begin
      rsp_valid_o[r_gnt] = 1'b1;
    end
  end

  assign rsp_result_o    = r_result;
  assign rsp_err_o       = r_err && (r_state == S_RESP);
  assign alu_op_a_o      = r_op_a;
  assign alu_op_b_o      = r_op_b;
  assign alu_opsel_o     = r_opsel;
  assign alu_trigger_o   = (r_state == S_ISSUE);
  assign alu_clear_err_o = r_clear_err;
  assign busy_o          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wide_alu_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_wide_alu_sched
// Desc   : Directed self-checking bench for wide_alu_sched (NUM_REQ=4, 32-bit ops).
// Rev    : 1.0  initial release
// ============================================================================
module tb_wide_alu_sched;

  localparam int NR = 4;
  localparam int OW = 32;
  localparam int RW = 64;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_ready_o;
  logic [NR*OW-1:0] req_op_a_i;
  logic [NR*OW-1:0] req_op_b_i;
  logic [NR*3-1:0]  req_opsel_i;
  logic [NR-1:0]    rsp_valid_o;
  logic [NR-1:0]    rsp_ready_i;
  logic [RW-1:0]    rsp_result_o;
  logic             rsp_err_o;
  logic [OW-1:0]    alu_op_a_o;
  logic [OW-1:0]    alu_op_b_o;
  logic [2:0]       alu_opsel_o;
  logic             alu_trigger_o;
  logic             alu_clear_err_o;
  logic             alu_done_i;
  logic             alu_err_i;
  logic [RW-1:0]    alu_result_i;
  logic             busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wide_alu_sched #(
    .NUM_REQ    (NR),
    .OP_WIDTH   (OW),
    .RES_WIDTH  (RW),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_a_i     (req_op_a_i),
    .req_op_b_i     (req_op_b_i),
    .req_opsel_i    (req_opsel_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_result_o   (rsp_result_o),
    .rsp_err_o      (rsp_err_o),
    .alu_op_a_o     (alu_op_a_o),
    .alu_op_b_o     (alu_op_b_o),
    .alu_opsel_o    (alu_opsel_o),
    .alu_trigger_o  (alu_trigger_o),
    .alu_clear_err_o(alu_clear_err_o),
    .alu_done_i     (alu_done_i),
    .alu_err_i      (alu_err_i),
    .alu_result_i   (alu_result_i),
    .busy_o         (busy_o)
  );

  // Reference ALU used only to answer the DUT's trigger.
  function automatic logic [RW-1:0] alu_model(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                               input logic [2:0] s);
    case (s)
      3'd0:    return RW'(a) + RW'(b);
      3'd1:    return RW'(a) - RW'(b);
      3'd2:    return RW'(a) * RW'(b);
      3'd3:    return RW'(a ^ b);
      3'd4:    return RW'(a & b);
      3'd5:    return RW'(a | b);
      default: return '0;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b,
                         input logic [2:0] s);
    req_op_a_i[i*OW +: OW] = a;
    req_op_b_i[i*OW +: OW] = b;
    req_opsel_i[i*3 +: 3]  = s;
  endtask

  task automatic do_reset;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_trigger(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk_i);
      if (alu_trigger_o) seen = 1'b1;
    end
  endtask

  task automatic alu_respond(input int delay, input bit done, input bit err);
    repeat (delay) @(negedge clk_i);
    alu_result_i = alu_model(alu_op_a_o, alu_op_b_o, alu_opsel_o);
    alu_done_i   = done;
    alu_err_i    = err;
    @(negedge clk_i);
    alu_done_i   = 1'b0;
    alu_err_i    = 1'b0;
    alu_result_i = '0;
  endtask

  task automatic test_reset;
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready_o); end
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid_o); end
    checks++; if ({alu_trigger_o, alu_clear_err_o, rsp_err_o} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b exp 000", {alu_trigger_o, alu_clear_err_o, rsp_err_o}); end
    checks++; if ({rsp_result_o, alu_op_a_o, alu_op_b_o} !== '0) begin
      errors++; $display("FAIL reset_regs got %h exp 0", {rsp_result_o, alu_op_a_o, alu_op_b_o}); end
    rst_i = 1'b0;
  endtask

  task automatic test_single_add;
    bit seen;
    int trig_cnt;
    set_req(0, 32'd5, 32'd7, 3'd0);
    req_valid_i = 4'b0001;
    #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL add_ready got %b exp 0001", req_ready_o); end
    wait_trigger(seen);
    req_valid_i = '0;
    checks++; if (!seen) begin errors++; $display("FAIL add_trigger got 0 exp 1"); end
    checks++; if ({alu_op_a_o, alu_op_b_o, alu_opsel_o} !== {32'd5, 32'd7, 3'd0}) begin
      errors++; $display("FAIL add_operands got %h/%h/%0d exp 5/7/0", alu_op_a_o, alu_op_b_o, alu_opsel_o); end
    trig_cnt = seen ? 1 : 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_i);
      if (alu_trigger_o) trig_cnt++;
    end
    alu_result_i = alu_model(alu_op_a_o, alu_op_b_o, alu_opsel_o);
    alu_done_i   = 1'b1;
    @(negedge clk_i);
    alu_done_i   = 1'b0;
    checks++; if (trig_cnt !== 1) begin errors++; $display("FAIL add_trig_count got %0d exp 1", trig_cnt); end
    checks++; if (rsp_valid_o !== 4'b0001) begin errors++; $display("FAIL add_rsp_valid got %b exp 0001", rsp_valid_o); end
    checks++; if (rsp_result_o !== 64'd12) begin errors++; $display("FAIL add_result got %0d exp 12", rsp_result_o); end
    checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", rsp_err_o); end
    rsp_ready_i = 4'b0001;
    @(negedge clk_i);
    rsp_ready_i = '0;
    checks++; if ({busy_o, rsp_valid_o} !== 5'b0) begin
      errors++; $display("FAIL add_idle got busy=%b valid=%b exp 0/0000", busy_o, rsp_valid_o); end
  endtask

  task automatic test_round_robin;
    bit seen;
    logic [3:0] exp;
    int order[5]   = '{0, 1, 2, 3, 0};
    int exp_res[5] = '{11, 22, 33, 44, 11};
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, OW'(10 * (i + 1)), OW'(i + 1), 3'd0);
    req_valid_i = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp = 4'b0001 << order[n];
      #1;
      checks++; if (req_ready_o !== exp) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", n, req_ready_o, exp); end
      wait_trigger(seen);
      checks++; if (!seen) begin errors++; $display("FAIL rr_trigger[%0d] got 0 exp 1", n); end
      alu_respond(1, 1'b1, 1'b0);
      checks++; if (rsp_valid_o !== exp) begin errors++; $display("FAIL rr_rsp_valid[%0d] got %b exp %b", n, rsp_valid_o, exp); end
      checks++; if (rsp_result_o !== RW'(exp_res[n])) begin
        errors++; $display("FAIL rr_result[%0d] got %0d exp %0d", n, rsp_result_o, exp_res[n]); end
      checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL rr_ready_in_resp[%0d] got %b exp 0000", n, req_ready_o); end
      rsp_ready_i = exp;
      @(negedge clk_i);
      rsp_ready_i = '0;
    end
    req_valid_i = '0;
  endtask

  task automatic test_bad_opsel;
    set_req(2, 32'h55, 32'h66, 3'd7);
    req_valid_i = 4'b0100;
    #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL bad_ready got %b exp 0100", req_ready_o); end
    @(negedge clk_i);
    req_valid_i = '0;
    checks++; if (alu_trigger_o !== 1'b0) begin errors++; $display("FAIL bad_trigger got 1 exp 0"); end
    checks++; if (rsp_valid_o !== 4'b0100) begin errors++; $display("FAIL bad_rsp_valid got %b exp 0100", rsp_valid_o); end
    checks++; if ({rsp_err_o, rsp_result_o} !== {1'b1, 64'd0}) begin
      errors++; $display("FAIL bad_err_result got err=%b res=%0d exp 1/0", rsp_err_o, rsp_result_o); end
    rsp_ready_i = 4'b1011;
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 4'b0100) begin errors++; $display("FAIL bad_foreign_ready got %b exp 0100", rsp_valid_o); end
    rsp_ready_i = 4'b0100;
    @(negedge clk_i);
    rsp_ready_i = '0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL bad_idle got %b exp 0", busy_o); end
  endtask

  task automatic test_err_priority;
    bit seen;
    int clr_cnt;
    set_req(1, 32'd3, 32'd4, 3'd2);
    req_valid_i = 4'b0010;
    wait_trigger(seen);
    req_valid_i = '0;
    checks++; if (!seen) begin errors++; $display("FAIL err_trigger got 0 exp 1"); end
    alu_respond(2, 1'b1, 1'b1);
    checks++; if (rsp_valid_o !== 4'b0010) begin errors++; $display("FAIL err_rsp_valid got %b exp 0010", rsp_valid_o); end
    checks++; if ({rsp_err_o, rsp_result_o} !== {1'b1, 64'd0}) begin
      errors++; $display("FAIL err_priority got err=%b res=%0d exp 1/0", rsp_err_o, rsp_result_o); end
    checks++; if (alu_clear_err_o !== 1'b1) begin errors++; $display("FAIL err_clear got 0 exp 1"); end
    clr_cnt = alu_clear_err_o ? 1 : 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk_i);
      if (alu_clear_err_o) clr_cnt++;
      checks++; if ({rsp_valid_o, rsp_err_o} !== 5'b0010_1) begin
        errors++; $display("FAIL err_hold[%0d] got %b/%b exp 0010/1", n, rsp_valid_o, rsp_err_o); end
    end
    checks++; if (clr_cnt !== 1) begin errors++; $display("FAIL err_clear_count got %0d exp 1", clr_cnt); end
    rsp_ready_i = 4'b0010;
    @(negedge clk_i);
    rsp_ready_i = '0;
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL err_release got %b exp 0000", rsp_valid_o); end
  endtask

  task automatic test_timeout;
    bit seen;
    set_req(3, 32'hF0, 32'h0F, 3'd3);
    req_valid_i = 4'b1000;
    wait_trigger(seen);
    req_valid_i = '0;
    checks++; if (!seen) begin errors++; $display("FAIL to_trigger got 0 exp 1"); end
`ifdef WIDE_ALU_SCHED_TIMEOUT_EN
    repeat (16) @(negedge clk_i);
    checks++; if (rsp_valid_o !== 4'b0000) begin errors++; $display("FAIL to_early got %b exp 0000", rsp_valid_o); end
    @(negedge clk_i);
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_result_o} !== {4'b1000, 1'b1, 64'd0}) begin
      errors++; $display("FAIL to_rsp got %b/%b/%0d exp 1000/1/0", rsp_valid_o, rsp_err_o, rsp_result_o); end
    rsp_ready_i = 4'b1000;
    @(negedge clk_i);
    rsp_ready_i = '0;
`else
    repeat (40) @(negedge clk_i);
    checks++; if ({busy_o, rsp_valid_o} !== 5'b1_0000) begin
      errors++; $display("FAIL to_hold got busy=%b valid=%b exp 1/0000", busy_o, rsp_valid_o); end
`endif
  endtask

  task automatic test_reset_mid_op;
    bit seen;
    do_reset();
    set_req(0, 32'd1, 32'd2, 3'd0);
    req_valid_i = 4'b0001;
    wait_trigger(seen);
    req_valid_i = '0;
    checks++; if (!seen) begin errors++; $display("FAIL rst_trigger got 0 exp 1"); end
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checks++; if ({busy_o, rsp_valid_o, alu_trigger_o, alu_clear_err_o} !== 7'b0) begin
      errors++; $display("FAIL rst_async got busy=%b valid=%b trig=%b clr=%b exp all 0",
                         busy_o, rsp_valid_o, alu_trigger_o, alu_clear_err_o); end
    @(negedge clk_i);
    rst_i        = 1'b0;
    alu_result_i = 64'd99;
    alu_done_i   = 1'b1;
    @(negedge clk_i);
    alu_done_i   = 1'b0;
    alu_result_i = '0;
    checks++; if ({busy_o, rsp_valid_o} !== 5'b0) begin
      errors++; $display("FAIL rst_late_done got busy=%b valid=%b exp 0/0000", busy_o, rsp_valid_o); end
    set_req(1, 32'hF0, 32'h0F, 3'd5);
    req_valid_i = 4'b0010;
    #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL rst_next_ready got %b exp 0010", req_ready_o); end
    wait_trigger(seen);
    req_valid_i = '0;
    alu_respond(1, 1'b1, 1'b0);
    checks++; if ({rsp_valid_o, rsp_err_o, rsp_result_o} !== {4'b0010, 1'b0, 64'hFF}) begin
      errors++; $display("FAIL rst_next_rsp got %b/%b/%h exp 0010/0/ff", rsp_valid_o, rsp_err_o, rsp_result_o); end
    rsp_ready_i = 4'b0010;
    @(negedge clk_i);
    rsp_ready_i = '0;
  endtask

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = '0;
    req_op_a_i   = '0;
    req_op_b_i   = '0;
    req_opsel_i  = '0;
    rsp_ready_i  = '0;
    alu_done_i   = 1'b0;
    alu_err_i    = 1'b0;
    alu_result_i = '0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_bad_opsel();
    test_err_priority();
    test_timeout();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
